// File: rtl/i_prefetch_buffer.sv
// One-line sequential prefetch buffer between the instruction cache and main memory.
// Demand reads/writes pass through; every demand read is followed by a fetch of line addr+1.
module i_prefetch_buffer #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter bit PF_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ready,
  output logic [DATA_W-1:0] c_rdata,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEMAND,
    S_WRITE,
    S_PREFETCH,
    S_RESP
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] lat_addr, pf_addr, buf_addr;
  logic [DATA_W-1:0] lat_wdata, resp_data, buf_data;
  logic              is_read, buf_valid, buf_hit;

  assign buf_hit = buf_valid && (buf_addr == c_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (c_write)     state_nxt = S_WRITE;
        else if (c_read) state_nxt = buf_hit ? S_RESP : S_DEMAND;
      end
      S_DEMAND:   if (m_ready) state_nxt = S_RESP;
      S_WRITE:    if (m_ready) state_nxt = S_RESP;
      // Only reads trigger a prefetch; writes and the pass-through build return to IDLE.
      S_RESP:     state_nxt = (PF_EN && is_read) ? S_PREFETCH : S_IDLE;
      S_PREFETCH: if (m_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      pf_addr   <= '0;
      resp_data <= '0;
      is_read   <= 1'b0;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (c_write) begin
            lat_addr  <= c_addr;
            lat_wdata <= c_wdata;
            resp_data <= '0;
            is_read   <= 1'b0;
            if (buf_hit) buf_valid <= 1'b0;
          end else if (c_read) begin
            lat_addr <= c_addr;
            pf_addr  <= c_addr + ADDR_W'(1);
            is_read  <= 1'b1;
            // A hit consumes the line; the follow-up prefetch refills with addr+1.
            if (buf_hit) begin
              resp_data <= buf_data;
              buf_valid <= 1'b0;
            end
          end
        end
        S_DEMAND: begin
          if (m_ready) resp_data <= m_rdata;
        end
        S_PREFETCH: begin
          if (m_ready) begin
            buf_data  <= m_rdata;
            buf_addr  <= pf_addr;
            buf_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // All interface outputs decode from registered state only, so m_ready never reaches c_ready.
  always_comb begin
    c_ready = 1'b0;
    c_rdata = '0;
    m_read  = 1'b0;
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    case (state)
      S_DEMAND: begin
        m_read = 1'b1;
        m_addr = lat_addr;
      end
      S_WRITE: begin
        m_write = 1'b1;
        m_addr  = lat_addr;
        m_wdata = lat_wdata;
      end
      S_PREFETCH: begin
        m_read = 1'b1;
        m_addr = pf_addr;
      end
      S_RESP: begin
        c_ready = 1'b1;
        c_rdata = resp_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i_prefetch_buffer.sv
// Randomized scoreboard bench for i_prefetch_buffer: a queue-based reference model predicts
// memory traffic and cache responses; independent monitor processes pop and compare.
module tb_i_prefetch_buffer;

  typedef struct {
    logic         is_write;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } mem_op_t;

  typedef struct {
    logic [127:0] data;
    logic         hit;
  } resp_t;

  logic         clk, rst_n;
  logic         c_read, c_write, c_ready, m_read, m_write, m_ready;
  logic [27:0]  c_addr, m_addr;
  logic [127:0] c_wdata, c_rdata, m_wdata, m_rdata;

  logic         c1_read, c1_write, c1_ready, m1_read, m1_write, m1_ready;
  logic [27:0]  c1_addr, m1_addr;
  logic [127:0] c1_wdata, c1_rdata, m1_wdata, m1_rdata;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int last_ack_cycle = 0;
  int lat_override = -1;
  int m1_reqs = 0;
  bit mem_en = 0;
  bit toggle_mode = 0;

  mem_op_t      exp_mem[$];
  resp_t        exp_resp[$];
  logic [127:0] ref_mem[logic [27:0]];
  logic [127:0] bench_mem[logic [27:0]];
  bit           mdl_valid = 0;
  logic [27:0]  mdl_buf_addr = '0;

  i_prefetch_buffer #(.ADDR_W(28), .DATA_W(128), .PF_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_rdata(c_rdata),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  i_prefetch_buffer #(.ADDR_W(28), .DATA_W(128), .PF_EN(1'b0)) dut_nopf (
    .clk(clk), .rst_n(rst_n),
    .c_read(c1_read), .c_write(c1_write), .c_addr(c1_addr), .c_wdata(c1_wdata),
    .c_ready(c1_ready), .c_rdata(c1_rdata),
    .m_read(m1_read), .m_write(m1_write), .m_addr(m1_addr), .m_wdata(m1_wdata),
    .m_rdata(m1_rdata), .m_ready(m1_ready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Unwritten memory lines hold a pattern derived from their address.
  function automatic logic [127:0] init_val(input logic [27:0] a);
    return {a, 4'h0, ~a, 4'hA, a ^ 28'h5A5A5A5, 4'h3, a[15:0], 16'hC0DE};
  endfunction

  function automatic logic [127:0] ref_val(input logic [27:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [127:0] bench_val(input logic [27:0] a);
    return bench_mem.exists(a) ? bench_mem[a] : init_val(a);
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Main memory for the prefetching instance: random latency, checks each new request.
  initial begin
    bit      busy;
    int      wait_cnt;
    mem_op_t op;
    busy = 0;
    wait_cnt = 0;
    m_ready = 0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      m_ready = 0;
      if (!mem_en) begin
        busy = 0;
        if (toggle_mode) begin
          m_ready = cycle[0];
          m_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if (m_read || m_write) begin
        if (!busy) begin
          busy = 1;
          wait_cnt = (lat_override >= 0) ? lat_override : int'($urandom_range(0, 4));
          checkOutput("mem_exclusive", 128'(m_read & m_write), 128'(0));
          if (exp_mem.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL mem_req: got write=%0b addr %h, expected no memory access", m_write, m_addr);
          end else begin
            op = exp_mem.pop_front();
            checkOutput("mem_kind", 128'(m_write), 128'(op.is_write));
            checkOutput("mem_addr", 128'(m_addr), 128'(op.addr));
            if (op.is_write) checkOutput("mem_wdata", m_wdata, op.wdata);
          end
        end
        if (wait_cnt == 0) begin
          m_ready = 1;
          if (m_write) begin
            bench_mem[m_addr] = m_wdata;
            m_rdata = {$urandom, $urandom, $urandom, $urandom};
          end else begin
            m_rdata = bench_val(m_addr);
          end
          busy = 0;
          last_ack_cycle = cycle;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Fixed-latency memory for the pass-through instance.
  initial begin
    bit b1;
    int cnt1;
    b1 = 0;
    cnt1 = 0;
    m1_ready = 0;
    m1_rdata = '0;
    forever begin
      @(negedge clk);
      m1_ready = 0;
      if (m1_read || m1_write) begin
        if (!b1) begin
          b1 = 1;
          cnt1 = 2;
          m1_reqs++;
        end
        if (cnt1 == 0) begin
          m1_ready = 1;
          m1_rdata = init_val(m1_addr);
          b1 = 0;
        end else begin
          cnt1--;
        end
      end
    end
  end

  // Response monitor: every c_ready pops one predicted response.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (mem_en && c_ready) begin
        if (exp_resp.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL c_ready: got unexpected response %h, expected none", c_rdata);
        end else begin
          r = exp_resp.pop_front();
          checkOutput("c_rdata", c_rdata, r.data);
          if (!r.hit) checkOutput("resp_latency", 128'(cycle), 128'(last_ack_cycle + 1));
        end
      end
    end
  end

  // Issues one cache request (caller is at a negedge), updates the model, waits for c_ready.
  task automatic applyStimulus(input bit wr, input logic [27:0] a, input logic [127:0] d,
                               output int lat);
    mem_op_t op;
    resp_t   r;
    bit      hit;
    if (wr) begin
      op.is_write = 1;
      op.addr = a;
      op.wdata = d;
      exp_mem.push_back(op);
      if (mdl_valid && mdl_buf_addr == a) mdl_valid = 0;
      ref_mem[a] = d;
      r.data = '0;
      r.hit = 0;
      exp_resp.push_back(r);
    end else begin
      hit = mdl_valid && (mdl_buf_addr == a);
      op.is_write = 0;
      op.wdata = '0;
      if (!hit) begin
        op.addr = a;
        exp_mem.push_back(op);
      end
      r.data = ref_val(a);
      r.hit = hit;
      exp_resp.push_back(r);
      op.addr = a + 28'd1;
      exp_mem.push_back(op);
      mdl_valid = 1;
      mdl_buf_addr = a + 28'd1;
    end
    c_write = wr;
    c_read = !wr;
    c_addr = a;
    c_wdata = d;
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (c_ready) break;
    end
    if (!c_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_timeout: got no c_ready for addr %h, expected one", a);
    end
    c_read = 0;
    c_write = 0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (n < 200 && (exp_mem.size() != 0 || m_read || m_write)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: got %0d pending memory ops, expected 0", exp_mem.size());
    end
  endtask

  task automatic pf0Read(input logic [27:0] a);
    int n;
    int seen;
    c1_read = 1;
    c1_addr = a;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (c1_ready) break;
    end
    checkOutput("pf0_ready", 128'(c1_ready), 128'(1));
    checkOutput("pf0_rdata", c1_rdata, init_val(a));
    c1_read = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (m1_read) seen++;
    end
    checkOutput("pf0_no_prefetch", 128'(seen), 128'(0));
  endtask

  initial begin
    int          lat;
    int          n;
    bit          wr;
    int          r;
    logic [27:0] a;
    logic [27:0] last_a;
    logic [127:0] d;

    rst_n = 0;
    c_read = 0; c_write = 0; c_addr = '0; c_wdata = '0;
    c1_read = 0; c1_write = 0; c1_addr = '0; c1_wdata = '0;
    toggle_mode = 1;
    repeat (4) @(negedge clk);
    checkOutput("rst_c_ready", 128'(c_ready), 128'(0));
    checkOutput("rst_c_rdata", c_rdata, 128'(0));
    checkOutput("rst_m_read", 128'(m_read), 128'(0));
    checkOutput("rst_m_write", 128'(m_write), 128'(0));
    checkOutput("rst_m_addr", 128'(m_addr), 128'(0));
    checkOutput("rst_m_wdata", m_wdata, 128'(0));
    toggle_mode = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Abort a demand read with an asynchronous reset.
    c_read = 1;
    c_addr = 28'h5;
    n = 0;
    while (n < 5 && !m_read) begin
      @(negedge clk);
      n++;
    end
    checkOutput("demand_started", 128'(m_read), 128'(1));
    #2 rst_n = 0;
    #1;
    checkOutput("abort_m_read", 128'(m_read), 128'(0));
    checkOutput("abort_m_addr", 128'(m_addr), 128'(0));
    c_read = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mem_en = 1;
    mdl_valid = 0;

    // Buffer must be invalid after reset even though buf_addr is 0.
    applyStimulus(0, 28'h0, '0, lat);
    waitIdle();

    lat_override = 4;
    applyStimulus(0, 28'h010, '0, lat);
    waitIdle();

    lat_override = 6;
    applyStimulus(0, 28'h011, '0, lat);
    checkOutput("hit_latency_011", 128'(lat), 128'(1));
    applyStimulus(0, 28'h030, '0, lat);
    lat_override = -1;
    waitIdle();
    applyStimulus(0, 28'h031, '0, lat);
    checkOutput("hit_latency_031", 128'(lat), 128'(1));
    waitIdle();

    applyStimulus(0, 28'h011, '0, lat);
    waitIdle();
    applyStimulus(1, 28'h012, {4{32'hFEEDF00D}}, lat);
    applyStimulus(0, 28'h012, '0, lat);
    waitIdle();

    applyStimulus(0, 28'hFFFFFFF, '0, lat);
    waitIdle();
    applyStimulus(0, 28'h0000000, '0, lat);
    checkOutput("hit_latency_wrap", 128'(lat), 128'(1));
    waitIdle();

    pf0Read(28'h040);
    pf0Read(28'h041);
    checkOutput("pf0_mem_reqs", 128'(m1_reqs), 128'(2));

    last_a = 28'h100;
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      a = last_a + 28'd1;
      else if (r < 5) a = last_a;
      else if (r < 6) a = 28'hFFFFFFF;
      else            a = 28'h100 + 28'($urandom_range(0, 7));
      wr = ($urandom_range(0, 3) == 0);
      d = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(wr, a, d, lat);
      last_a = a;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("resp_queue_empty", 128'(exp_resp.size()), 128'(0));
    checkOutput("mem_queue_empty", 128'(exp_mem.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
